// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: access-size encodings, sequencer states and beat-count helper
package mem_seq_pkg;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;
  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;
  function automatic logic [3:0] sz_beats(input logic [1:0] td);
    return 4'd1 << td;
  endfunction
endpackage

// File: rtl/mem_seq_if.sv
// mem_seq_if: control-unit MOV/MOC handshake plus byte-wide RAM bus
interface mem_seq_if #(parameter int DATA_W = 32, parameter int ADDR_W = 8);
  logic MOV, RW, SGN, MOC, ERR, mem_re, mem_we, mem_ready;
  logic [1:0] typeData;
  logic [ADDR_W-1:0] addr, mem_addr;
  logic [DATA_W-1:0] wdata, rdata;
  logic [7:0] mem_wdata, mem_rdata;
  modport slave (
    input  MOV, RW, typeData, SGN, addr, wdata, mem_rdata, mem_ready,
    output rdata, MOC, ERR, mem_addr, mem_re, mem_we, mem_wdata
  );
  modport master (
    output MOV, RW, typeData, SGN, addr, wdata, mem_rdata, mem_ready,
    input  rdata, MOC, ERR, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/mem_seq_lane.sv
// mem_seq_lane: byte shift assembler/disassembler with sign/zero extension
module mem_seq_lane #(
  parameter int DATA_W     = 32,
  parameter bit BIG_ENDIAN = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              ld,
  input  logic              shift,
  input  logic              fin,
  input  logic              sgn,
  input  logic [3:0]        n,
  input  logic [2:0]        b,
  input  logic [DATA_W-1:0] wdata,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] acc, acc_nx, wbuf, just, mask, msb;
  logic [6:0] nbits;
  logic [3:0] idx;
  // pick the outgoing byte, shift in the incoming one, right-justify and build the extension mask
  always_comb begin
    nbits = {n, 3'b000};
    idx = BIG_ENDIAN ? n - 4'd1 - {1'b0, b} : {1'b0, b};
    dout = 8'(wbuf >> {idx, 3'b000});
    acc_nx = BIG_ENDIAN ? {acc[DATA_W-9:0], din} : {din, acc[DATA_W-1:8]};
    just = BIG_ENDIAN ? acc_nx : acc_nx >> (7'(DATA_W) - nbits);
    mask = ~({DATA_W{1'b1}} << nbits);
    msb = mask & ~(mask >> 1);
  end
  // acc clears per request so unused upper bytes read as zero; rdata only moves on a completed read
  always_ff @(posedge clk)
    if (!clr) begin
      acc <= '0;
      wbuf <= '0;
      rdata <= '0;
    end else begin
      if (ld) begin
        acc <= '0;
        wbuf <= wdata;
      end else if (shift) acc <= acc_nx;
      if (fin) rdata <= (just & mask) | ({DATA_W{sgn && |(just & msb)}} & ~mask);
    end
endmodule

// File: rtl/mem_seq.sv
// mem_seq: MOV/MOC memory sequencer issuing byte beats to a wait-state RAM
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1
) (
  input logic     CLK,
  input logic     CLR,
  mem_seq_if.slave bus
);
  state_t state, state_nx;
  logic [2:0] b;
  logic [3:0] n, n_in;
  logic [ADDR_W-1:0] addr_r;
  logic rw_r, sgn_r, err_r, start, bad, beat, last, rd_beat;
  logic [7:0] dout;
  // request decode: beat count, size/alignment legality, beat qualifiers
  always_comb begin
    n_in = sz_beats(bus.typeData);
    bad = n_in > 4'(DATA_W / 8) || |(bus.addr[2:0] & 3'(n_in - 4'd1));
    start = state == IDLE && bus.MOV;
    beat = state == BEAT;
    last = b == 3'(n - 4'd1);
    rd_beat = beat && rw_r && bus.mem_ready;
  end
  // next state: errors skip straight to DONE, DONE waits for MOV to fall
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = bus.MOV ? (bad ? DONE : BEAT) : IDLE;
      BEAT:    state_nx = bus.mem_ready && last ? DONE : BEAT;
      DONE:    state_nx = bus.MOV ? DONE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge CLK) state <= !CLR ? IDLE : state_nx;
  // request latch and beat counter; inputs other than MOV are only sampled on acceptance
  always_ff @(posedge CLK)
    if (!CLR) begin
      b <= '0;
      n <= '0;
      addr_r <= '0;
      rw_r <= 1'b0;
      sgn_r <= 1'b0;
      err_r <= 1'b0;
    end else if (start) begin
      b <= '0;
      n <= n_in;
      addr_r <= bus.addr;
      rw_r <= bus.RW;
      sgn_r <= bus.SGN;
      err_r <= bad;
    end else if (beat && bus.mem_ready) b <= last ? 3'd0 : b + 3'd1;
  // strobes and address exist only in BEAT so they drop on the edge entering DONE
  always_comb begin
    bus.mem_addr = beat ? addr_r + ADDR_W'(b) : '0;
    bus.mem_re = beat && rw_r;
    bus.mem_we = beat && !rw_r;
    bus.mem_wdata = bus.mem_we ? dout : 8'h00;
    bus.MOC = state == DONE;
    bus.ERR = bus.MOC && err_r;
  end
  mem_seq_lane #(.DATA_W(DATA_W), .BIG_ENDIAN(BIG_ENDIAN)) lane (
    .clk   (CLK),
    .clr   (CLR),
    .ld    (start),
    .shift (rd_beat),
    .fin   (rd_beat && last),
    .sgn   (sgn_r),
    .n     (n),
    .b     (b),
    .wdata (bus.wdata),
    .din   (bus.mem_rdata),
    .dout  (dout),
    .rdata (bus.rdata)
  );
endmodule

// File: doc/mem_seq.md
# mem_seq

Parametrised memory access sequencer between the control unit's MOV/MOC handshake and a byte-wide RAM. It generalises the single-cycle, fixed 32-bit RAM access path to any multiple-of-8 data width. It adds multi-beat byte sequencing with memory wait states, selectable endianness, sign/zero extension and alignment checking. MAR drives the address; MDR loads read data through MUXE and supplies write data through MUXG.

## Interface
- DATA_W, 32, data width in bits; multiple of 8, 16..64
- ADDR_W, 8, byte-address width
- BIG_ENDIAN, 1, 1: lowest address holds most-significant byte
- CLK  in  1  clock; all state changes on rising edge
- CLR  in  1  reset, synchronous, active-low
- MOV  in  1  request; held high by control unit until MOC seen
- RW  in  1  1 = read, 0 = write
- typeData  in  2  access size: 00 byte, 01 halfword, 10 word, 11 doubleword (legal only if DATA_W = 64)
- SGN  in  1  read extension: 1 sign-extend, 0 zero-extend
- addr  in  ADDR_W  byte address (MAR)
- wdata  in  DATA_W  write data, right-justified (MDR)
- rdata  out  DATA_W  read data, right-justified and extended
- MOC  out  1  operation complete
- ERR  out  1  valid with MOC: misaligned or illegal size
- mem_addr  out  ADDR_W  byte address to RAM
- mem_re  out  1  read strobe
- mem_we  out  1  write strobe
- mem_wdata  out  8  write byte
- mem_rdata  in  8  read byte; valid when mem_ready = 1
- mem_ready  in  1  RAM completes current byte beat

## Operation
- States: IDLE, BEAT, DONE.
- IDLE: on MOV = 1, latch RW, typeData, SGN, addr and wdata. Set the beat count N = 1, 2, 4 or 8 bytes.
- Illegal size, N > DATA_W/8, or addr not a multiple of N: go to DONE with ERR = 1. No strobe is issued.
- Otherwise set the beat counter b = 0 and go to BEAT.
- BEAT: mem_addr = addr + b. mem_re = RW, mem_we = !RW, held stable until mem_ready = 1.
- Beat order is always ascending address.
- Byte mapping: big-endian, beat b carries item byte N-1-b; little-endian, it carries byte b.
- On a mem_ready edge, a read shifts mem_rdata into the assembler. If b = N-1, go to DONE; else b++.
- DONE: MOC = 1. ERR stays as set. rdata is valid and held.
- Leave DONE for IDLE on the first edge with MOV = 0. MOC drops with the exit.
- Reads are extended from N·8 bits to DATA_W using SGN.
- Writes leave rdata unchanged. Errors also leave rdata unchanged.
- Inputs other than MOV are ignored outside IDLE.
- mem_addr wraps modulo 2^ADDR_W. This is unreachable for aligned accesses.
- Reset when CLR = 0 at an edge:
  - state IDLE; b = 0
  - MOC, ERR, mem_re, mem_we = 0
  - rdata, mem_addr, mem_wdata = 0
- Reset mid-BEAT abandons the access. Bytes already written stay written.

## Timing
- Edge 0 is the edge where MOV is sampled high in IDLE.
- mem_re/mem_we and mem_addr for beat 0 are valid after edge 0.
- Each beat costs 1 + w cycles, where w is the number of mem_ready-low cycles.
- Latency with w = 0: MOC high after edge N.
- Word with w = 2: MOC high after edge 12.
- Error path: MOC and ERR high after edge 0, with no strobe cycle.
- MOC is held while MOV stays high. A new request needs at least one IDLE cycle after MOV falls.
- If MOV is already low when entering DONE, MOC is high for exactly one cycle.
- Strobes deassert on the same edge that enters DONE.

## Structure
- Package mem_seq_pkg holds:
  - size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD)
  - the state enum
  - function sz_beats(typeData), returning N
- One sub-module, mem_seq_lane, parametrised by DATA_W. It is the shift-register assembler/disassembler plus extension logic.
- The FSM, beat counter and alignment check stay in mem_seq.

## Test plan
- Word read, big-endian:
  - Stimulus: RAM[0x10..0x13] = DE AD BE EF; word read at 0x10, SGN = 0, mem_ready = 1.
  - Response: mem_addr steps 0x10 to 0x13; rdata = 0xDEADBEEF; MOC after edge 4; ERR = 0.
- Signed byte read:
  - Stimulus: byte read at 0x11, SGN = 1.
  - Response: rdata = 0xFFFFFFAD.
  - Same with SGN = 0: rdata = 0x000000AD.
  - With BIG_ENDIAN = 0: word read at 0x10 gives 0xEFBEADDE.
- Halfword write:
  - Stimulus: wdata = 0x00001234 to 0x20, big-endian.
  - Response: RAM[0x20] = 0x12, RAM[0x21] = 0x34; two mem_we beats; MOC after edge 2; rdata unchanged.
- Wait states:
  - Stimulus: word read with mem_ready low for 2 cycles per beat.
  - Response: mem_addr is stable during stalls; MOC after edge 12; MOV held high keeps MOC high; MOC drops one edge after MOV falls.
- Errors:
  - Word read at 0x11 gives MOC = ERR = 1 after edge 0, with no mem_re/mem_we pulse.
  - typeData = 11 with DATA_W = 32 gives the same response.
  - typeData = 11 with DATA_W = 64: RAM DE AD BE EF 01 02 03 04 gives 0xDEADBEEF01020304.
- Reset mid-operation:
  - Stimulus: CLR = 0 during beat 2 of a word write to 0x30.
  - Response: next cycle, state is IDLE, all outputs 0, RAM[0x30..0x31] written and RAM[0x32..0x33] untouched.
  - A new request after CLR = 1 completes normally.
